// File: rtl/xcorr_peak_tdoa_if.sv
//============================================================================
// Module      : xcorr_peak_tdoa_if
// Description : Sample-stream and result bus of the cross-correlation
//               peak / arrival-time-difference block.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface xcorr_peak_tdoa_if #(
    parameter int CH    = 2,
    parameter int W     = 40,
    parameter int CNT_W = 24
);
    logic                            s_valid;
    logic [CH*W-1:0]                 S_DATA;
    logic                            busy;
    logic                            res_valid;
    logic [CH*W-1:0]                 PEAK_VAL;
    logic [CH*CNT_W-1:0]             PEAK_IDX;
    logic [(CH-1)*(CNT_W+1)-1:0]     TDOA;
    logic [CH-1:0]                   MISS;

    modport master (
        output s_valid, S_DATA,
        input  busy, res_valid, PEAK_VAL, PEAK_IDX, TDOA, MISS
    );

    modport slave (
        input  s_valid, S_DATA,
        output busy, res_valid, PEAK_VAL, PEAK_IDX, TDOA, MISS
    );
endinterface

`default_nettype wire

// File: rtl/xcorr_peak_tdoa.sv
//============================================================================
// Module      : xcorr_peak_tdoa
// Description : Hysteresis-triggered per-channel peak search over a window,
//               reporting peaks and signed index difference versus channel 0.
//               Optional macro ABS_INPUT_EN: signed lanes, magnitude used.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module xcorr_peak_tdoa #(
    parameter int CH    = 2,
    parameter int W     = 40,
    parameter int CNT_W = 24
) (
    input  wire              clkf,
    input  wire              rst,
    xcorr_peak_tdoa_if.slave bus,
    input  wire  [W-1:0]     THR_HI,
    input  wire  [W-1:0]     THR_LO,
    input  wire  [CNT_W-1:0] WIN_LEN
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_REPORT = 2'd2,
        S_REARM  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic            w_vld;
    logic [CH*W-1:0] w_data;

`ifdef ABS_INPUT_EN
    logic            r_vld;
    logic [CH*W-1:0] r_data;
    logic [CH*W-1:0] w_mag;

    // Most negative code has no positive twin; clamp it to the largest positive.
    for (genvar k = 0; k < CH; k++) begin : g_abs
        logic [W-1:0] w_x;
        assign w_x = bus.S_DATA[k*W +: W];
        assign w_mag[k*W +: W] = !w_x[W-1] ? w_x :
                                 (w_x == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} :
                                 (-w_x);
    end

    always_ff @(posedge clkf) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            r_vld  <= bus.s_valid;
            r_data <= w_mag;
        end
    end

    assign w_vld  = r_vld;
    assign w_data = r_data;
`else
    assign w_vld  = bus.s_valid;
    assign w_data = bus.S_DATA;
`endif

    logic [W-1:0]     w_lane [CH];
    logic [W-1:0]     r_max  [CH];
    logic [CNT_W-1:0] r_idx  [CH];
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_win_len;
    logic [W-1:0]     r_thr_lo;

    logic [CH-1:0]                w_miss;
    logic [CH*W-1:0]              w_pval;
    logic [CH*CNT_W-1:0]          w_pidx;
    logic [(CH-1)*(CNT_W+1)-1:0]  w_tdoa;

    logic [CH*W-1:0]              r_peak_val;
    logic [CH*CNT_W-1:0]          r_peak_idx;
    logic [(CH-1)*(CNT_W+1)-1:0]  r_tdoa;
    logic [CH-1:0]                r_miss;
    logic                         r_res_valid;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        assign w_lane[k]               = w_data[k*W +: W];
        assign w_miss[k]               = (r_max[k] < r_thr_lo);
        assign w_pval[k*W +: W]        = r_max[k];
        assign w_pidx[k*CNT_W +: CNT_W] = r_idx[k];
    end

    // Indices are zero-extended by one bit, so the difference always fits.
    for (genvar k = 1; k < CH; k++) begin : g_tdoa
        assign w_tdoa[(k-1)*(CNT_W+1) +: CNT_W+1] =
            (w_miss[k] || w_miss[0]) ? '0 : ({1'b0, r_idx[k]} - {1'b0, r_idx[0]});
    end

    logic w_trig;
    logic w_rearm;
    logic w_short;
    logic w_last;

    assign w_trig  = w_vld && (w_lane[0] > THR_HI);
    assign w_rearm = w_vld && (w_lane[0] < r_thr_lo);
    assign w_short = (WIN_LEN <= CNT_W'(1));
    assign w_last  = w_vld && (r_cnt == (r_win_len - CNT_W'(1)));

    always_ff @(posedge clkf) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_trig)  w_state_nxt = w_short ? S_REPORT : S_WINDOW;
            S_WINDOW: if (w_last)  w_state_nxt = S_REPORT;
            S_REPORT:              w_state_nxt = S_REARM;
            S_REARM:  if (w_rearm) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clkf) begin
        if (rst) begin
            r_cnt       <= '0;
            r_win_len   <= '0;
            r_thr_lo    <= '0;
            r_peak_val  <= '0;
            r_peak_idx  <= '0;
            r_tdoa      <= '0;
            r_miss      <= '0;
            r_res_valid <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                r_max[k] <= '0;
                r_idx[k] <= '0;
            end
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_cnt     <= CNT_W'(1);
                        r_win_len <= WIN_LEN;
                        r_thr_lo  <= THR_LO;
                        for (int k = 0; k < CH; k++) begin
                            r_max[k] <= w_lane[k];
                            r_idx[k] <= '0;
                        end
                    end
                end
                S_WINDOW: begin
                    if (w_vld) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Strict compare keeps the earliest index on ties.
                        for (int k = 0; k < CH; k++) begin
                            if (w_lane[k] > r_max[k]) begin
                                r_max[k] <= w_lane[k];
                                r_idx[k] <= r_cnt;
                            end
                        end
                    end
                end
                S_REPORT: begin
                    r_peak_val  <= w_pval;
                    r_peak_idx  <= w_pidx;
                    r_tdoa      <= w_tdoa;
                    r_miss      <= w_miss;
                    r_res_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.res_valid = r_res_valid;
    assign bus.PEAK_VAL  = r_peak_val;
    assign bus.PEAK_IDX  = r_peak_idx;
    assign bus.TDOA      = r_tdoa;
    assign bus.MISS      = r_miss;

endmodule

`default_nettype wire
